// File: rtl/riscv32i_sim_ctrl_pkg.sv
// Shared types and constants for the riscv32i simulation run controller:
// FSM state encoding, tohost word encoding and default snoop addresses.
package riscv32i_simctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } sim_state_t;

  // A tohost word with bit 0 set ends the run; exactly 1 means pass.
  localparam int PASS_WORD       = 1;
  localparam int TOHOST_FAIL_BIT = 0;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_1004;

endpackage

// File: rtl/riscv32i_sim_ctrl_sat_counter.sv
// Saturating up-counter: clears on clr, advances on en, and stops at the
// value presented on max instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != max)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/riscv32i_sim_ctrl.sv
// Run controller for the riscv32i core: holds core reset, counts run cycles,
// snoops tohost/console stores. Optional watchdog via SIMCTRL_WATCHDOG_EN.
module riscv32i_sim_ctrl
  import riscv32i_simctrl_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 50000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEFAULT_CONSOLE_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-2:0] fail_code,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              con_valid,
  output logic [7:0]        con_data
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES);

  sim_state_t        state_reg, state_next;
  logic [DATA_W-2:0] fail_code_reg, fail_code_next;
  logic              con_valid_reg, con_valid_next;
  logic [7:0]        con_data_reg, con_data_next;
  logic [HOLD_W-1:0] hold_count;
  logic              in_run, in_hold;
  logic              tohost_sel, console_sel, tohost_end;
  logic              cycle_en, watchdog_hit;

  assign in_run      = (state_reg == ST_RUN);
  assign in_hold     = (state_reg == ST_HOLD);
  assign tohost_sel  = wr_en && (wr_addr == TOHOST_ADDR);
  assign console_sel = wr_en && (wr_addr == CONSOLE_ADDR);
  assign tohost_end  = in_run && tohost_sel && wr_data[TOHOST_FAIL_BIT];

  // A terminating tohost store freezes the count at the value of that edge.
  assign cycle_en = in_run && !tohost_end;

  sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (in_hold),
    .max   (HOLD_LAST),
    .count (hold_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (cycle_en),
    .max   ({CNT_W{1'b1}}),
    .count (cycle_count)
  );

`ifdef SIMCTRL_WATCHDOG_EN
  assign watchdog_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout      = (state_reg == ST_TIMEOUT);
`else
  assign watchdog_hit = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    fail_code_next = fail_code_reg;
    con_valid_next = in_run && console_sel;
    con_data_next  = con_data_reg;
    if (con_valid_next) begin
      con_data_next = wr_data[7:0];
    end
    case (state_reg)
      ST_HOLD: begin
        if (hold_count == HOLD_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A tohost verdict on the watchdog edge takes priority.
        if (tohost_end) begin
          if (wr_data == DATA_W'(PASS_WORD)) begin
            state_next = ST_PASS;
          end else begin
            state_next     = ST_FAIL;
            fail_code_next = wr_data[DATA_W-1:1];
          end
        end else if (watchdog_hit) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_HOLD;
      fail_code_reg <= '0;
      con_valid_reg <= 1'b0;
      con_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      fail_code_reg <= fail_code_next;
      con_valid_reg <= con_valid_next;
      con_data_reg  <= con_data_next;
    end
  end

  assign core_reset = !in_run;
  assign running    = in_run;
  assign done       = !in_run && !in_hold;
  assign pass       = (state_reg == ST_PASS);
  assign fail_code  = fail_code_reg;
  assign con_valid  = con_valid_reg;
  assign con_data   = con_data_reg;

endmodule

// File: doc/riscv32i_sim_ctrl.md
# riscv32i_sim_ctrl

Parametrised run controller for the riscv32i core in simulation and FPGA bring-up. It generates the core reset with a configurable hold length and counts run cycles. It snoops the core's data-bus writes for a tohost pass/fail word and a console byte port, and latches a final status. It sits between the top-level clock/reset and the core's `reset` input, passively tapping the store bus.

## Interface
- `ADDR_W`, 32, snooped address width
- `DATA_W`, 32, snooped data width (≥8)
- `CNT_W`, 32, cycle counter width
- `RESET_CYCLES`, 4, cycles `core_reset` stays high after `reset` falls (≥1)
- `TIMEOUT_CYCLES`, 50000, run cycles before timeout
- `TOHOST_ADDR`, 32'h0000_1000, pass/fail word address
- `CONSOLE_ADDR`, 32'h0000_1004, console byte address

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: core store strobe, one cycle per store
- `wr_addr` in ADDR_W: store address
- `wr_data` in DATA_W: store data
- `core_reset` out 1: reset to the core
- `running` out 1: in RUN state
- `done` out 1: terminal state reached, sticky
- `pass` out 1: tohost reported pass
- `fail_code` out DATA_W-1: tohost fail code
- `timeout` out 1: watchdog expired
- `cycle_count` out CNT_W: run cycles, saturating
- `con_valid` out 1: console byte strobe
- `con_data` out 8: console byte

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until `reset`.
- HOLD: `core_reset`=1. A hold counter counts 0..RESET_CYCLES-1, then the block moves to RUN.
- RUN: `core_reset`=0 and `cycle_count` increments each cycle. It saturates at all-ones and never wraps.
- Store with `wr_addr`==TOHOST_ADDR in RUN:
  - `wr_data`==1 -> PASS.
  - `wr_data[0]`==1, any other value -> FAIL, `fail_code`=`wr_data[DATA_W-1:1]`.
  - `wr_data[0]`==0 -> ignored.
- Store with `wr_addr`==CONSOLE_ADDR in RUN -> `con_valid` pulses for one cycle with `con_data`=`wr_data[7:0]`.
- Terminal states: `core_reset` is re-asserted, which halts the core. `cycle_count` freezes. All stores are ignored.
- Stores during HOLD are ignored.

## Timing
- Reset values: `core_reset`=1, and `running`, `done`, `pass`, `timeout`, `con_valid` = 0. `fail_code`, `cycle_count`, `con_data` = 0.
- `reset` low at edge k -> `core_reset` low after edge k+RESET_CYCLES; `running` goes high at the same edge.
- Status outputs are registered. A tohost store sampled at edge n drives `done`/`pass`/`fail_code` valid after edge n; `cycle_count` holds that edge's value.
- Console: store sampled at edge n -> `con_valid` high for exactly the cycle after edge n. Back-to-back stores give back-to-back pulses.
- Watchdog: TIMEOUT is entered at the edge where `cycle_count` would reach TIMEOUT_CYCLES.
- Tohost store and timeout on the same edge: tohost wins.
- `reset` asserted in any state, including mid-run: next edge returns to HOLD and clears all outputs to reset values.

## Configuration
- `SIMCTRL_WATCHDOG_EN` defined: watchdog as described.
- Not defined: no TIMEOUT state, `timeout` tied 0, TIMEOUT_CYCLES unused. RUN continues until tohost or `reset`, and `cycle_count` still saturates.

## Structure
- `riscv32i_simctrl_pkg` holds:
  - state enum
  - tohost encodings (PASS_WORD=1, fail flag = bit 0)
  - default address localparams
- One sub-module, `sat_counter`, parametrised on width, with `clr`/`en`/`max` signals. It is instantiated for the hold counter and for `cycle_count`.
- Address decode and FSM live in the top module.

## Test plan
- RESET_CYCLES=4, release `reset` at edge 2 -> `core_reset` falls after edge 6; `cycle_count`=0 then 1,2,…
- Store 0x1000 ← 1 at run cycle 100 -> `done`=`pass`=1, `cycle_count`=100 frozen, `core_reset`=1.
- Store 0x1000 ← 0x0000_0007 -> FAIL, `fail_code`=3, `pass`=0. A later store 0x1000 ← 1 is ignored.
- Three consecutive stores to 0x1004 of 0x48, 0x69, 0x0A -> three consecutive `con_valid` pulses with matching `con_data`. A store to 0x1000 ← 2 changes nothing.
- TIMEOUT_CYCLES=20 with `SIMCTRL_WATCHDOG_EN`:
  - No stores -> `timeout`=`done`=1 at count 20.
  - Tohost ← 1 on that same edge -> PASS instead.
  - Without the macro -> still RUN at cycle 1000.
- `reset` pulse mid-run at cycle 50 -> HOLD next edge, all outputs at reset values, RESET_CYCLES hold repeats.
